// File: rtl/game_pkg.sv
// Shared definitions for the memory-game note blocks (playback and answer checking).
package game_pkg;

  localparam int NOTE_W    = 4;
  localparam int MAX_STEPS = 8;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } chk_state_e;

  // Step i of a pattern occupies bits [4i+3:4i].
  function automatic logic [NOTE_W-1:0] note_at(
    input logic [NOTE_W*MAX_STEPS-1:0] pattern,
    input logic [2:0]                  index
  );
    return pattern[index*NOTE_W +: NOTE_W];
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad nibble into the clk domain.
module key_sync
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] key,
  output logic [NOTE_W-1:0] key_s
);

  logic [NOTE_W-1:0] meta_q;
  logic [NOTE_W-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= key;
      sync_q <= meta_q;
    end
  end

  assign key_s = sync_q;

endmodule

// File: rtl/answer_checker.sv
// Checks player key presses against the latched note pattern one step at a time,
// reporting hit/miss/round_done pulses and keeping a saturating round score.
//
// state           | meaning
// ST_IDLE         | waiting for start from the controller
// ST_WAIT_PRESS   | step timer running, waiting for a non-zero key
// ST_WAIT_RELEASE | correct note held, waiting for key release
module answer_checker
  import game_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 200,
  parameter int SCORE_W       = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        pattern_in,
  input  logic [3:0]         max_index_in,
  input  logic [3:0]         key,
  input  logic               tick,
  output logic               busy,
  output logic [3:0]         expect_index,
  output logic               hit,
  output logic               miss,
  output logic               round_done,
  output logic [3:0]         led_echo,
  output logic [SCORE_W-1:0] score
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_TICKS - 1);
  localparam logic [2:0]         LAST_STEP  = 3'(MAX_STEPS - 1);

  logic [NOTE_W-1:0]  key_s;
  logic [NOTE_W-1:0]  note_cur;

  chk_state_e         state_q, state_d;
  logic [31:0]        pattern_q, pattern_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         idx_q, idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               done_q, done_d;
  logic [NOTE_W-1:0]  led_q, led_d;
  logic [SCORE_W-1:0] score_q, score_d;

  key_sync u_key_sync (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .key_s (key_s)
  );

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    last_d    = last_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    led_d     = led_q;
    score_d   = score_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    done_d    = 1'b0;
    note_cur  = note_at(pattern_q, idx_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pattern_d = pattern_in;
          last_d    = max_index_in[3] ? LAST_STEP : max_index_in[2:0];
          idx_d     = '0;
          timer_d   = '0;
          state_d   = ST_WAIT_PRESS;
        end
      end

      ST_WAIT_PRESS: begin
        // A zero nibble never equals a non-zero key, so such a step can only miss.
        if (key_s != '0) begin
          if (key_s == note_cur) begin
            hit_d   = 1'b1;
            led_d   = key_s;
            state_d = ST_WAIT_RELEASE;
          end else begin
            miss_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          if (timer_q == TIMER_LAST) begin
            miss_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      ST_WAIT_RELEASE: begin
        if (key_s == '0) begin
          led_d = '0;
          if (idx_q == last_q) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
            if (score_q != {SCORE_W{1'b1}}) begin
              score_d = score_q + 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            timer_d = '0;
            state_d = ST_WAIT_PRESS;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        led_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      last_q    <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= '0;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      done_q    <= done_d;
      led_q     <= led_d;
      score_q   <= score_d;
    end
  end

  assign busy         = busy_q;
  assign expect_index = {1'b0, idx_q};
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign round_done   = done_q;
  assign led_echo     = led_q;
  assign score        = score_q;

endmodule

// File: doc/answer_checker.md
# answer_checker

Player-side counterpart to the note playback block in the memory game. Playback sends a stored 32-bit pattern of eight 4-bit notes to piezo/LED; this block receives the player's key presses and checks each one against the same pattern, step by step. It reports hit, miss and round-complete to the game controller and keeps a saturating score. It sits between the keypad encoder and the game controller, alongside the playback block.

## Interface
Parameters:
- TIMEOUT_TICKS, 200: `tick` pulses allowed per step before a timeout miss (≥1).
- SCORE_W, 7: score counter width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; returns block to IDLE.
- start  in  1  one-cycle pulse from the controller once playback has finished.
- pattern_in  in  32  note pattern; step i = bits [4i+3:4i]; sampled on accepted `start`.
- max_index_in  in  4  index of the last step in the round; sampled on accepted `start`; values >7 clamp to 7.
- key  in  4  raw keypad note, asynchronous; 0 = no key.
- tick  in  1  one-cycle timebase pulse from the shared prescaler.
- busy  out  1  high in WAIT_PRESS and WAIT_RELEASE.
- expect_index  out  4  step currently expected.
- hit  out  1  one-cycle pulse on a correct note.
- miss  out  1  one-cycle pulse on a wrong note or timeout; ends the round.
- round_done  out  1  one-cycle pulse after the last step is released.
- led_echo  out  4  note being held by a correct press, else 0.
- score  out  SCORE_W  completed rounds; saturates at all-ones.

## Operation
- `key` passes through a 2-flop synchronizer, giving `key_s`. The FSM only ever sees `key_s`.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE.
- IDLE:
  - busy=0.
  - On `start`: latch the pattern and the clamped last index, set expect_index=0, clear the step timer, go to WAIT_PRESS.
- WAIT_PRESS:
  - If `key_s` ≠ 0 and equals the nibble at expect_index: pulse hit, set led_echo=`key_s`, go to WAIT_RELEASE.
  - If `key_s` ≠ 0 and does not match: pulse miss, set expect_index=0, go to IDLE.
  - Else on each `tick`, increment the timer. On the `tick` that makes the count reach TIMEOUT_TICKS: pulse miss, go to IDLE.
- WAIT_RELEASE:
  - No timeout is active here.
  - When `key_s` = 0: set led_echo=0.
  - If expect_index equals the last index: pulse round_done, increment score (saturating), set expect_index=0, go to IDLE.
  - Otherwise: increment expect_index, clear the timer, go to WAIT_PRESS.
- A pattern nibble of 0 can never be matched. Any press on that step is a miss, and so is a timeout.
- `start` while busy is ignored; latched pattern and index are unchanged.
- Key press and timeout `tick` in the same cycle: the key is evaluated and the timeout is discarded.
- hit, miss and round_done are mutually exclusive in any cycle.

## Timing
- Reset values:
  - outputs: busy=0, expect_index=0, hit=0, miss=0, round_done=0, led_echo=0, score=0.
  - internal: state=IDLE, timer=0, synchronizer flops=0.
- Reset asserted mid-round aborts immediately: no miss pulse, and score is kept only if reset is not asserted (reset clears it).
- `start` sampled at edge N: busy=1 and expect_index=0 after edge N.
- Key input latency: `key` changes before edge N; `key_s` is valid after edge N+1; hit or miss is asserted after edge N+2 for exactly one cycle.
- Release latency: `key` falls to 0 before edge N; round_done pulses (last step) or expect_index advances after edge N+2.
- All outputs are registered; there are no combinational input-to-output paths.
- Timer width = clog2(TIMEOUT_TICKS+1).

## Structure
- Shared package `game_pkg`:
  - constants NOTE_W=4 and MAX_STEPS=8;
  - the checker state enum;
  - a nibble-select function (pattern, index) → note, also usable by the playback block.
- Sub-module `key_sync`: 2-flop synchronizer on the 4-bit key, output `key_s`.
- Everything else (FSM, step timer, score) lives in the top module.

## Test plan
- Correct round: pattern_in=32'h0000_0321, max_index_in=2, start; press 1, release, press 2, release, press 3, release → three hit pulses, one round_done, score=1, busy=0.
- Wrong note: same pattern; press 1, release, press 4 → hit, then miss, busy=0, expect_index=0, score unchanged.
- Timeout: TIMEOUT_TICKS=3, start, no key, three `tick` pulses → miss after the 3rd tick; a key press coincident with the 3rd tick instead produces hit or miss with no timeout miss.
- Clamp and ignore: max_index_in=9 with pattern 32'h8765_4321 → round needs all 8 steps, round_done after step 7; a second `start` mid-round changes nothing.
- Saturation and reset: SCORE_W=2, complete 4 rounds → score stays 3; assert reset while in WAIT_RELEASE → all outputs return to reset values with no hit/miss/round_done pulse.
